im_loader: RTL and testbench

//  Boot-time writer for the 1 KB instruction memory that the fetch unit reads.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Packs every 4 bytes into one big-endian 32-bit instruction word.
//  - Writes the words to consecutive word-aligned IM addresses, starting at byte address 0.
//  - Holds the CPU in reset (cpu_reset) until a complete image has been written.

---
 rtl/im_loader.sv | 119 +++++++++++
 tb/tb_im_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
// Packs a byte stream into big-endian 32-bit words, writes them to
// consecutive word-aligned IM addresses from 0, and holds the CPU in
// reset until a complete image has been written.
module im_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-2:0] len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_reset
);

    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam int CW    = ADDR_W - 2;   // word counter width
    localparam int LW    = ADDR_W - 1;   // length width (can hold WORDS)

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [1:0]    byte_cnt_q;
    logic [CW-1:0] word_cnt_q;
    logic [LW-1:0] len_q;
    logic [31:0]   buffer_q;
    logic          loaded_q;

    logic [LW-1:0] len_clamped_d;
    logic          last_word_d;
    logic          abort_act_d;
    logic          handshake_d;

    // Request decode: clamp the requested length so waddr never wraps,
    // and flag the final word of the current image.
    always_comb begin
        len_clamped_d = (len > LW'(WORDS)) ? LW'(WORDS) : len;
        last_word_d   = ({1'b0, word_cnt_q} == (len_q - LW'(1)));
        abort_act_d   = abort & (state_q != S_IDLE);
        handshake_d   = in_valid & in_ready;
    end

    // Loader FSM with its datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            buffer_q   <= '0;
            loaded_q   <= 1'b0;
        end else if (abort_act_d) begin
            // Cancelled load: the partial image stays unflagged.
            state_q  <= S_IDLE;
            loaded_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        if (len != '0) begin
                            state_q  <= S_RECV;
                            len_q    <= len_clamped_d;
                            loaded_q <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RECV: begin
                    if (handshake_d) begin
                        buffer_q   <= {buffer_q[23:0], in_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    byte_cnt_q <= '0;
                    word_cnt_q <= word_cnt_q + CW'(1);
                    state_q    <= last_word_d ? S_DONE : S_RECV;
                end
                S_DONE: begin
                    loaded_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode; abort suppresses the byte accept, the write strobe
    // and the completion pulse in the same cycle.
    always_comb begin
        busy      = (state_q != S_IDLE);
        in_ready  = (state_q == S_RECV)  & ~abort;
        we        = (state_q == S_WRITE) & ~abort;
        done      = (state_q == S_DONE)  & ~abort;
        waddr     = {word_cnt_q, 2'b00};
        wdata     = buffer_q;
        cpu_reset = ~loaded_q | busy;
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for im_loader. The stimulus side pushes
// expected IM writes and done pulses; a negedge monitor pops and compares.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  len = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        cpu_reset;

    typedef struct packed {
        logic        is_done;
        logic [9:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    im_loader #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .cpu_reset(cpu_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every write strobe or done pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset && (we || done)) begin
            ev_t e;
            tests++;
            if (we && done) begin
                fails++;
                $display("FAIL strobe: we and done both high at %0t", $time);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected: we=%0b done=%0b waddr=0x%0h wdata=0x%0h, nothing expected",
                         we, done, waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done != done || (we && (e.addr != waddr || e.data != wdata))) begin
                    fails++;
                    $display("FAIL event: got done=%0b addr=0x%0h data=0x%0h expected done=%0b addr=0x%0h data=0x%0h",
                             done, waddr, wdata, e.is_done, e.addr, e.data);
                end else if (we) begin
                    $display("[TB] write 0x%03h <= 0x%08h", waddr, wdata);
                end else begin
                    $display("[TB] done pulse");
                end
            end
        end
    end

    task automatic push_write(input logic [9:0] a, input logic [31:0] d);
        exp_q.push_back('{is_done: 1'b0, addr: a, data: d});
    endtask

    task automatic push_done();
        exp_q.push_back('{is_done: 1'b1, addr: '0, data: '0});
    endtask

    task automatic start_load(input logic [8:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout: byte 0x%0h not accepted, in_ready=%0b", b, in_ready);
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 3));
                in_valid = 1'b0;
                in_data  = 8'hEE;
                repeat (g) begin @(posedge clk); #1; end
            end
            send_byte(w[31 - 8*i -: 8]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL %s: busy never cleared", name);
        end
    endtask

    initial begin
        // 1: reset values while asserted and after release
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_we",        32'(we),        32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("post_rst_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;

        // 2: two-word image back to back
        push_write(10'h000, 32'h3C080001);
        push_write(10'h004, 32'h20090002);
        push_done();
        start_load(9'd2);
        @(negedge clk);
        check("t2_in_ready_after_start", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_word(32'h3C080001, 1'b0);
        send_word(32'h20090002, 1'b0);
        in_valid = 1'b0;
        wait_idle("t2_idle");
        check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // 3: same image with gaps in the stream
        push_write(10'h000, 32'h3C080001);
        push_write(10'h004, 32'h20090002);
        push_done();
        start_load(9'd2);
        @(negedge clk);
        check("t3_cpu_reset_during", 32'(cpu_reset), 32'd1);
        @(posedge clk); #1;
        send_word(32'h3C080001, 1'b1);
        send_word(32'h20090002, 1'b1);
        in_valid = 1'b0;
        wait_idle("t3_idle");
        check("t3_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // 4: abort after the 6th byte; only the first word is written
        push_write(10'h000, 32'h11223344);
        start_load(9'd2);
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        in_data = 8'h77;
        abort   = 1'b1;
        @(negedge clk);
        check("t4_in_ready_abort", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("t4_cpu_reset_hold", 32'(cpu_reset), 32'd1);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // 5a: zero-length load completes with no write
        push_done();
        start_load(9'd0);
        wait_idle("t5_idle");
        check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t5_queue", 32'(exp_q.size()), 32'd0);

        // 5b: start while busy is ignored
        push_write(10'h000, 32'hA1B2C3D4);
        push_done();
        start_load(9'd1);
        send_byte(8'hA1);
        in_valid = 1'b0;
        start_load(9'd2);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        in_valid = 1'b0;
        wait_idle("t5b_idle");
        check("t5b_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t5b_queue", 32'(exp_q.size()), 32'd0);

        // 6a: oversize length is clamped to 256 words
        for (int i = 0; i < 256; i++) begin
            push_write(10'(i * 4), {8'(i), ~8'(i), 8'hA5, 8'(i * 3)});
        end
        push_done();
        start_load(9'd300);
        for (int i = 0; i < 256; i++) begin
            send_word({8'(i), ~8'(i), 8'hA5, 8'(i * 3)}, 1'b0);
        end
        in_valid = 1'b0;
        wait_idle("t6_idle");
        check("t6_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t6_queue", 32'(exp_q.size()), 32'd0);

        // 6b: async reset mid-RECV drops every output at once
        start_load(9'd3);
        send_byte(8'h12);
        send_byte(8'h34);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_in_ready",  32'(in_ready),  32'd0);
        check("t6_rst_we",        32'(we),        32'd0);
        check("t6_rst_busy",      32'(busy),      32'd0);
        check("t6_rst_done",      32'(done),      32'd0);
        check("t6_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_rst_waddr",     32'(waddr),     32'd0);
        check("t6_rst_wdata",     wdata,          32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_after_cpu_reset", 32'(cpu_reset), 32'd1);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
